// File: rtl/vram_pkg.sv
// Shared VRAM definitions: cell geometry, the {y, x} address packing used by
// both the bus decoder and the fill arbiter, and the fill FSM encoding.
package vram_pkg;

    localparam int X_BITS = 8;               // column index width, addr[7:0]
    localparam int Y_BITS = 6;               // row index width, addr[13:8]
    localparam int D_BITS = 11;              // VRAM cell data width
    localparam int A_BITS = X_BITS + Y_BITS; // packed cell address width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    // Cell address packing: row in the upper bits, column in the lower bits.
    function automatic logic [A_BITS-1:0] pack_addr(
        input logic [Y_BITS-1:0] y,
        input logic [X_BITS-1:0] x
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/vram_fill_scan.sv
// Rectangle cursor for the fill engine.
// Holds the rectangle bounds and walks the cursor row-major over it.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears bounds and cursor)
//   load           capture x0/x1/y0/y1 and place the cursor at (x0, y0)
//   adv            step the cursor one cell; ignored when already on the last cell
//   x0, x1, y0, y1 rectangle bounds, inclusive, sampled on load
//   cx, cy         current cursor column / row
//   last           cursor sits on the bottom-right cell (cx == x1 && cy == y1)
module vram_fill_scan
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic [X_BITS-1:0] x0,
    input  logic [X_BITS-1:0] x1,
    input  logic [Y_BITS-1:0] y0,
    input  logic [Y_BITS-1:0] y1,
    output logic [X_BITS-1:0] cx,
    output logic [Y_BITS-1:0] cy,
    output logic              last
);

    logic [X_BITS-1:0] x0_q;
    logic [X_BITS-1:0] x1_q;
    logic [Y_BITS-1:0] y1_q;

    assign last = (cx == x1_q) && (cy == y1_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            cx   <= '0;
            cy   <= '0;
        end else if (load) begin
            x0_q <= x0;
            x1_q <= x1;
            y1_q <= y1;
            cx   <= x0;
            cy   <= y0;
        end else if (adv && !last) begin
            // Holding on the last cell keeps the cursor from wrapping past y1.
            if (cx == x1_q) begin
                cx <= x0_q;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_fill_arbiter.sv
// Owner of the single VRAM write port. Merges CPU writes with a hardware
// rectangle-fill engine; the CPU always wins and the fill engine takes every
// cycle the CPU leaves idle.
// Strobe semantics: cpu_we is a one-cycle write strobe with no back-pressure
// (the CPU is always granted); vram_we is a registered one-cycle strobe that
// qualifies vram_addr/vram_data in the same cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_we/cpu_addr/cpu_data CPU cell write, address packed {y, x}
//   fill_start               one-cycle pulse, starts a fill from IDLE
//   fill_abort               level, ends a running fill at the next edge
//   fill_x0/x1/y0/y1         inclusive rectangle, latched on start
//   fill_data                fill value, latched on start
//   vram_we/addr/data        registered VRAM write port
//   fill_busy                high while the FSM is in FILL
//   fill_done                registered one-cycle pulse, the cycle after DONE
module vram_fill_arbiter
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [A_BITS-1:0] cpu_addr,
    input  logic [D_BITS-1:0] cpu_data,
    input  logic              fill_start,
    input  logic              fill_abort,
    input  logic [X_BITS-1:0] fill_x0,
    input  logic [X_BITS-1:0] fill_x1,
    input  logic [Y_BITS-1:0] fill_y0,
    input  logic [Y_BITS-1:0] fill_y1,
    input  logic [D_BITS-1:0] fill_data,
    output logic              vram_we,
    output logic [A_BITS-1:0] vram_addr,
    output logic [D_BITS-1:0] vram_data,
    output logic              fill_busy,
    output logic              fill_done
);

    // FSM state kept as a named signal so checkers can bind to it directly.
    fill_state_t       state;
    fill_state_t       state_next;

    logic [D_BITS-1:0] fdata_q;
    logic [X_BITS-1:0] cx;
    logic [Y_BITS-1:0] cy;
    logic              last;
    logic [A_BITS-1:0] cursor_addr;

    logic              load;
    logic              fill_run;
    logic              fill_grant;
    logic              collision;
    logic              adv;
    logic              empty_rect;

    assign cursor_addr = pack_addr(cy, cx);
    assign load        = (state == ST_IDLE) && fill_start;
    assign empty_rect  = (fill_x0 > fill_x1) || (fill_y0 > fill_y1);

    // An abort suppresses the fill grant in the same cycle it is seen.
    assign fill_run    = (state == ST_FILL) && !fill_abort;
    assign fill_grant  = fill_run && !cpu_we;
    // A CPU write onto the cursor cell counts as that cell being filled,
    // so the CPU value is never overwritten by the engine.
    assign collision   = fill_run && cpu_we && (cpu_addr == cursor_addr);
    assign adv         = fill_grant || collision;

    vram_fill_scan u_scan (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .adv  (adv),
        .x0   (fill_x0),
        .x1   (fill_x1),
        .y0   (fill_y0),
        .y1   (fill_y1),
        .cx   (cx),
        .cy   (cy),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (fill_start) begin
                    state_next = empty_rect ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_abort) begin
                    state_next = ST_DONE;
                end else if (adv && last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fdata_q <= '0;
        end else if (load) begin
            fdata_q <= fill_data;
        end
    end

    // Registered write port: CPU first, then the fill engine; otherwise the
    // strobe drops and address/data hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else if (cpu_we) begin
            vram_we   <= 1'b1;
            vram_addr <= cpu_addr;
            vram_data <= cpu_data;
        end else if (fill_grant) begin
            vram_we   <= 1'b1;
            vram_addr <= cursor_addr;
            vram_data <= fdata_q;
        end else begin
            vram_we   <= 1'b0;
        end
    end

    // The done pulse follows the DONE cycle; a reset while in FILL or DONE
    // therefore never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_done <= 1'b0;
        end else begin
            fill_done <= (state == ST_DONE);
        end
    end

    assign fill_busy = (state == ST_FILL);

endmodule

// File: tb/tb_vram_fill_arbiter.sv
module tb_vram_fill_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [10:0] cpu_data;
    logic        fill_start;
    logic        fill_abort;
    logic [7:0]  fill_x0;
    logic [7:0]  fill_x1;
    logic [5:0]  fill_y0;
    logic [5:0]  fill_y1;
    logic [10:0] fill_data;
    logic        vram_we;
    logic [13:0] vram_addr;
    logic [10:0] vram_data;
    logic        fill_busy;
    logic        fill_done;

    vram_fill_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_x0    (fill_x0),
        .fill_x1    (fill_x1),
        .fill_y0    (fill_y0),
        .fill_y1    (fill_y1),
        .fill_data  (fill_data),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus and scoreboard state ----------------
    typedef struct packed {
        logic        start;
        logic        abort;
        logic        rst;
        logic        cwe;
        logic [13:0] caddr;
        logic [10:0] cdata;
    } stim_t;

    stim_t       stim_q[$];
    // Expected per-cycle outputs: {busy, done, we, addr[13:0], data[10:0]}
    logic [27:0] exp_q[$];
    logic [13:0] last_addr;
    logic [10:0] last_data;
    logic [10:0] shadow [0:16383];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t st(input logic start, input logic abort, input logic r,
                                 input logic cwe, input logic [13:0] a, input logic [10:0] d);
        stim_t s;
        s.start = start;
        s.abort = abort;
        s.rst   = r;
        s.cwe   = cwe;
        s.caddr = a;
        s.cdata = d;
        return s;
    endfunction

    // Cycle whose result is a VRAM write of (a, d).
    task automatic wr(input stim_t s, input logic busy, input logic [13:0] a, input logic [10:0] d);
        last_addr = a;
        last_data = d;
        stim_q.push_back(s);
        exp_q.push_back({busy, 1'b0, 1'b1, a, d});
    endtask

    // Cycle with no VRAM write: address/data hold the previous write.
    task automatic idle(input stim_t s, input logic busy, input logic done);
        stim_q.push_back(s);
        exp_q.push_back({busy, done, 1'b0, last_addr, last_data});
    endtask

    task automatic set_rect(input logic [7:0] x0, input logic [7:0] x1,
                            input logic [5:0] y0, input logic [5:0] y1, input logic [10:0] d);
        fill_x0   = x0;
        fill_x1   = x1;
        fill_y0   = y0;
        fill_y1   = y1;
        fill_data = d;
    endtask

    // Plays the queued stimulus one cycle at a time and compares every cycle.
    // start2_at >= 0 injects a second fill_start with a different rectangle.
    task automatic run_seq(input string tag, input int start2_at);
        stim_t       s;
        logic [27:0] e;
        logic [27:0] o;
        int          i;
        i = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            fill_start = s.start;
            fill_abort = s.abort;
            rst        = s.rst;
            cpu_we     = s.cwe;
            cpu_addr   = s.caddr;
            cpu_data   = s.cdata;
            if (i == start2_at) begin
                fill_start = 1'b1;
                set_rect(8'd0, 8'd0, 6'd0, 6'd0, 11'h001);
            end
            tick();
            o = {fill_busy, fill_done, vram_we, vram_addr, vram_data};
            check_eq($sformatf("%s[%0d]", tag, i), {4'h0, o}, {4'h0, e});
            if (vram_we) shadow[vram_addr] = vram_data;
            i++;
        end
        fill_start = 1'b0;
        fill_abort = 1'b0;
        rst        = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_data   = '0;
    endtask

    // The small rectangle used by several tests: x 2..4, y 1..2.
    task automatic small_plain(input stim_t s0);
        idle(s0, 1'b1, 1'b0);
        wr(st(0,0,0,0,0,0), 1'b1, 14'h0102, 11'h7FF);
        wr(st(0,0,0,0,0,0), 1'b1, 14'h0103, 11'h7FF);
        wr(st(0,0,0,0,0,0), 1'b1, 14'h0104, 11'h7FF);
        wr(st(0,0,0,0,0,0), 1'b1, 14'h0202, 11'h7FF);
        wr(st(0,0,0,0,0,0), 1'b1, 14'h0203, 11'h7FF);
        wr(st(0,0,0,0,0,0), 1'b0, 14'h0204, 11'h7FF);
        idle(st(0,0,0,0,0,0), 1'b0, 1'b1);
        idle(st(0,0,0,0,0,0), 1'b0, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        stim_t n;
        stim_t s;
        n = st(0,0,0,0,0,0);
        s = st(1,0,0,0,0,0);

        rst        = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_data   = '0;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        set_rect(8'd0, 8'd0, 6'd0, 6'd0, 11'h000);
        last_addr  = '0;
        last_data  = '0;
        for (int i = 0; i < 16384; i++) shadow[i] = '0;

        tick();
        tick();
        check_eq("rst_we",   {31'd0, vram_we},   32'd0);
        check_eq("rst_addr", {18'd0, vram_addr}, 32'd0);
        check_eq("rst_data", {21'd0, vram_data}, 32'd0);
        check_eq("rst_busy", {31'd0, fill_busy}, 32'd0);
        check_eq("rst_done", {31'd0, fill_done}, 32'd0);
        rst = 1'b0;
        tick();

        // Reset after five writes of a full-screen fill: no done pulse.
        set_rect(8'd0, 8'd255, 6'd0, 6'd63, 11'h155);
        idle(s, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) wr(n, 1'b1, 14'(i), 11'h155);
        last_addr = '0;
        last_data = '0;
        idle(st(0,0,1,0,0,0), 1'b0, 1'b0);
        idle(n, 1'b0, 1'b0);
        idle(n, 1'b0, 1'b0);
        idle(n, 1'b0, 1'b0);
        run_seq("rst_mid", -1);

        // Plain small fill.
        set_rect(8'd2, 8'd4, 6'd1, 6'd2, 11'h7FF);
        small_plain(s);
        run_seq("plain", -1);

        // CPU write elsewhere on the third fill cycle.
        set_rect(8'd2, 8'd4, 6'd1, 6'd2, 11'h7FF);
        idle(s, 1'b1, 1'b0);
        wr(n, 1'b1, 14'h0102, 11'h7FF);
        wr(n, 1'b1, 14'h0103, 11'h7FF);
        wr(st(0,0,0,1,14'h3F00,11'h123), 1'b1, 14'h3F00, 11'h123);
        wr(n, 1'b1, 14'h0104, 11'h7FF);
        wr(n, 1'b1, 14'h0202, 11'h7FF);
        wr(n, 1'b1, 14'h0203, 11'h7FF);
        wr(n, 1'b0, 14'h0204, 11'h7FF);
        idle(n, 1'b0, 1'b1);
        idle(n, 1'b0, 1'b0);
        run_seq("cpu_other", -1);

        // CPU write onto the cursor cell: fill skips it, CPU value survives.
        set_rect(8'd2, 8'd4, 6'd1, 6'd2, 11'h7FF);
        idle(s, 1'b1, 1'b0);
        wr(n, 1'b1, 14'h0102, 11'h7FF);
        wr(st(0,0,0,1,14'h0103,11'h055), 1'b1, 14'h0103, 11'h055);
        wr(n, 1'b1, 14'h0104, 11'h7FF);
        wr(n, 1'b1, 14'h0202, 11'h7FF);
        wr(n, 1'b1, 14'h0203, 11'h7FF);
        wr(n, 1'b0, 14'h0204, 11'h7FF);
        idle(n, 1'b0, 1'b1);
        idle(n, 1'b0, 1'b0);
        run_seq("collide", -1);
        check_eq("cell_0103", {21'd0, shadow[14'h0103]}, 32'h055);
        check_eq("cell_0104", {21'd0, shadow[14'h0104]}, 32'h7FF);

        // Degenerate rectangle: no writes, done two cycles after start.
        set_rect(8'd5, 8'd3, 6'd0, 6'd0, 11'h003);
        idle(s, 1'b0, 1'b0);
        idle(n, 1'b0, 1'b1);
        idle(n, 1'b0, 1'b0);
        run_seq("empty", -1);

        // Second start while busy is ignored.
        set_rect(8'd2, 8'd4, 6'd1, 6'd2, 11'h7FF);
        small_plain(s);
        run_seq("restart", 2);

        // Abort after the second write of a full-screen fill.
        set_rect(8'd0, 8'd255, 6'd0, 6'd63, 11'h2AA);
        idle(s, 1'b1, 1'b0);
        wr(n, 1'b1, 14'h0000, 11'h2AA);
        wr(n, 1'b1, 14'h0001, 11'h2AA);
        idle(st(0,1,0,0,0,0), 1'b0, 1'b0);
        idle(n, 1'b0, 1'b1);
        idle(n, 1'b0, 1'b0);
        idle(n, 1'b0, 1'b0);
        run_seq("abort", -1);

        // Start and abort together: zero fill writes.
        set_rect(8'd0, 8'd255, 6'd0, 6'd63, 11'h0F0);
        idle(st(1,1,0,0,0,0), 1'b1, 1'b0);
        idle(st(0,1,0,0,0,0), 1'b0, 1'b0);
        idle(n, 1'b0, 1'b1);
        idle(n, 1'b0, 1'b0);
        run_seq("start_abort", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
